// File: rtl/fetch_decode_buffer_if.sv
//==============================================================================
// Module      : fetch_decode_buffer_if
// Description : Fetch/decode handshake and redirect bundle for the instruction
//               queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fetch_decode_buffer_if;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc_plus4;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] decode_instruction;
  logic [31:0] decode_pc_plus4;
  logic        decode_valid;
  logic        decode_ready;
  logic [31:0] jump_address;
  logic        branch_condition;

  modport slave (
    input  fetch_instruction, fetch_pc_plus4, fetch_valid, flush, decode_ready,
    output fetch_ready, decode_instruction, decode_pc_plus4, decode_valid,
           jump_address, branch_condition
  );

  modport master (
    output fetch_instruction, fetch_pc_plus4, fetch_valid, flush, decode_ready,
    input  fetch_ready, decode_instruction, decode_pc_plus4, decode_valid,
           jump_address, branch_condition
  );
endinterface

`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
//==============================================================================
// Module      : fetch_decode_buffer
// Description : Circular instruction queue between fetch and decode with J-type
//               redirect and squash. Optional STALL_COUNTER_EN adds stall_count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_decode_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [5:0]  J_OPCODE = 6'b000010
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  fetch_decode_buffer_if.slave  bus
`ifdef STALL_COUNTER_EN
  ,
  output      logic [15:0]      stall_count
`endif
);

  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_jump_address;
  logic             r_branch;

  logic             w_valid;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_redirect;
  logic             w_squash;
  logic [31:0]      w_head_instr;
  logic [31:0]      w_head_pc;

  assign w_valid      = (r_count != '0);
  assign w_ready      = (r_count != CNT_W'(DEPTH));
  assign w_push       = bus.fetch_valid & w_ready;
  assign w_pop        = w_valid & bus.decode_ready;
  assign w_head_instr = r_mem[r_rd_ptr][63:32];
  assign w_head_pc    = r_mem[r_rd_ptr][31:0];
  // A flush overrides a J pop: the popped jump is on a wrong path itself.
  assign w_redirect   = w_pop & (w_head_instr[31:26] == J_OPCODE) & ~bus.flush;
  assign w_squash     = bus.flush | w_redirect;

  assign bus.fetch_ready        = w_ready;
  assign bus.decode_valid       = w_valid;
  assign bus.decode_instruction = w_valid ? w_head_instr : 32'h0;
  assign bus.decode_pc_plus4    = w_valid ? w_head_pc    : 32'h0;
  assign bus.jump_address       = r_jump_address;
  assign bus.branch_condition   = r_branch;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.fetch_instruction, bus.fetch_pc_plus4};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_jump_address <= 32'h0;
      r_branch       <= 1'b0;
    end else begin
      r_branch <= w_redirect;
      if (w_redirect) begin
        r_jump_address <= {w_head_pc[31:28], w_head_instr[25:0], 2'b00};
      end
      if (w_squash) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= 16'h0;
    end else if (w_valid && !bus.decode_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
//==============================================================================
// Module      : tb_fetch_decode_buffer
// Description : Scoreboard bench for fetch_decode_buffer (STALL_COUNTER_EN aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_decode_buffer;

  localparam logic [5:0] J_OP = 6'b000010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_decode_buffer_if bus ();

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count;
`endif

  fetch_decode_buffer dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .bus         (bus)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] sb [$];
  logic        exp_bc = 1'b0;
  logic [31:0] exp_ja = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: compare against state after the last edge, then advance
  // the model by what the coming edge will do.
  always @(negedge clk) begin
    logic        push, pop, jpop;
    logic [63:0] head;
    if (!rst_n) begin
      sb.delete();
      exp_bc = 1'b0;
      exp_ja = 32'h0;
    end
    head = 64'h0;
    if (sb.size() != 0) head = sb[0];
    chk("decode_valid",       32'(bus.decode_valid),     32'(sb.size() != 0));
    chk("fetch_ready",        32'(bus.fetch_ready),      32'(sb.size() < 4));
    chk("branch_condition",   32'(bus.branch_condition), 32'(exp_bc));
    chk("jump_address",       bus.jump_address,          exp_ja);
    chk("decode_instruction", bus.decode_instruction,    head[63:32]);
    chk("decode_pc_plus4",    bus.decode_pc_plus4,       head[31:0]);
    if (rst_n) begin
      push   = bus.fetch_valid && (sb.size() < 4);
      pop    = (sb.size() != 0) && bus.decode_ready;
      jpop   = pop && (head[63:58] == J_OP);
      exp_bc = 1'b0;
      if (bus.flush) begin
        sb.delete();
      end else if (jpop) begin
        exp_bc = 1'b1;
        exp_ja = {head[31:28], head[57:32], 2'b00};
        sb.delete();
      end else begin
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back({bus.fetch_instruction, bus.fetch_pc_plus4});
      end
    end
  end

  initial begin
    bus.fetch_instruction = 32'h0;
    bus.fetch_pc_plus4    = 32'h0;
    bus.fetch_valid       = 1'b0;
    bus.flush             = 1'b0;
    bus.decode_ready      = 1'b0;

    step();
    step();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();

    // Fill to capacity; the fifth offer must be refused
    for (int i = 0; i < 5; i++) begin
      bus.fetch_valid       = 1'b1;
      bus.fetch_instruction = 32'(32'h11111111 * (i + 1));
      bus.fetch_pc_plus4    = 32'h00001004 + 32'(4 * i);
      step();
    end
    bus.fetch_valid = 1'b0;
    chk("full_fetch_ready",  32'(bus.fetch_ready),  32'd0);
    chk("full_decode_valid", 32'(bus.decode_valid), 32'd1);
    chk("full_head",         bus.decode_instruction, 32'h11111111);
    bus.decode_ready = 1'b1;
    repeat (5) step();
    bus.decode_ready = 1'b0;
    chk("drained_valid", 32'(bus.decode_valid), 32'd0);

    // Streaming across pointer wrap
    bus.fetch_valid  = 1'b1;
    bus.decode_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.fetch_instruction = 32'hA0000000 + 32'(i);
      bus.fetch_pc_plus4    = 32'h00002000 + 32'(4 * i);
      step();
    end
    bus.fetch_valid = 1'b0;
    step();
    bus.decode_ready = 1'b0;
    step();

    // J at head followed by a plain entry
    bus.fetch_valid       = 1'b1;
    bus.fetch_instruction = 32'h08000010;
    bus.fetch_pc_plus4    = 32'h00400008;
    step();
    bus.fetch_instruction = 32'h22222222;
    bus.fetch_pc_plus4    = 32'h0040000C;
    step();
    bus.fetch_valid  = 1'b0;
    bus.decode_ready = 1'b1;
    step();
    bus.decode_ready = 1'b0;
    chk("jump_pulse",      32'(bus.branch_condition), 32'd1);
    chk("jump_target",     bus.jump_address,          32'h00000040);
    chk("jump_squashed",   32'(bus.decode_valid),     32'd0);
    step();
    chk("jump_pulse_end",  32'(bus.branch_condition), 32'd0);
    chk("jump_target_hold", bus.jump_address,         32'h00000040);

    // Flush in the same cycle as a J pop and a push
    bus.fetch_valid       = 1'b1;
    bus.fetch_instruction = 32'h08000100;
    bus.fetch_pc_plus4    = 32'h00500004;
    step();
    bus.fetch_instruction = 32'h33333333;
    bus.fetch_pc_plus4    = 32'h00500008;
    bus.flush             = 1'b1;
    bus.decode_ready      = 1'b1;
    step();
    bus.flush        = 1'b0;
    bus.fetch_valid  = 1'b0;
    bus.decode_ready = 1'b0;
    chk("flush_no_pulse", 32'(bus.branch_condition), 32'd0);
    chk("flush_empty",    32'(bus.decode_valid),     32'd0);
    chk("flush_ja_kept",  bus.jump_address,          32'h00000040);
    step();
    chk("flush_still_empty", 32'(bus.decode_valid), 32'd0);

    // Asynchronous reset in the middle of traffic
    bus.fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_instruction = 32'h5A5A0001 + 32'(i);
      bus.fetch_pc_plus4    = 32'h00003000 + 32'(4 * i);
      step();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_decode_valid", 32'(bus.decode_valid),     32'd0);
    chk("rst_fetch_ready",  32'(bus.fetch_ready),      32'd1);
    chk("rst_branch",       32'(bus.branch_condition), 32'd0);
    chk("rst_jump_address", bus.jump_address,          32'h0);
    chk("rst_decode_instr", bus.decode_instruction,    32'h0);
    bus.fetch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", 32'(bus.decode_valid), 32'd0);

`ifdef STALL_COUNTER_EN
    bus.fetch_valid       = 1'b1;
    bus.fetch_instruction = 32'h44444444;
    bus.fetch_pc_plus4    = 32'h00004004;
    step();
    bus.fetch_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_saturated", 32'(stall_count), 32'h0000FFFF);
    bus.decode_ready = 1'b1;
    step();
    bus.decode_ready = 1'b0;
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
